// File: rtl/core_control.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/execute/
// mem/writeback over the Wishbone bus, raises traps and counts retired instructions.
module core_control #(
  parameter int unsigned BUS_TIMEOUT = 16,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [6:0]  instr_opcode_in,
  input  logic        branch_taken_in,
  input  logic        bus_ack_in,
  input  logic        bus_err_in,
  output logic        bus_cyc_out,
  output logic        bus_stb_out,
  output logic        bus_we_out,
  output logic        bus_addr_sel_out,
  output logic        instr_latch_out,
  output logic        operand_latch_out,
  output logic        load_latch_out,
  output logic        writeback_out,
  output logic        pc_update_out,
  output logic [1:0]  pc_sel_out,
  output logic        trap_out,
  output logic [1:0]  trap_cause_out,
  output logic [2:0]  state_out,
  output logic [31:0] instret_out
);

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned CAUSE_W  = 2;
  localparam int unsigned INSTRET_W = 32;

  localparam logic [OPCODE_W-1:0] OP_ARITH_R = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ARITH_I = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH  = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL     = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR    = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LOAD    = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE   = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_LUI     = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC   = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_SYSTEM  = 7'b1110011;

  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_BUS_ERR = 2'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_REL  = 2'b01;
  localparam logic [1:0] PC_SEL_REG  = 2'b10;
  localparam logic [1:0] PC_SEL_TRAP = 2'b11;

  // Last counter value before expiry; only meaningful when the timeout is enabled.
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(BUS_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX  = {TIMEOUT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [TIMEOUT_W-1:0]   timeout_cnt;
  logic [CAUSE_W-1:0]     cause_next;
  logic                   timeout_hit;
  logic                   is_load;
  logic                   is_store;
  logic                   is_legal;
  logic                   writes_rd;

  assign state_out   = state;
  assign timeout_hit = (BUS_TIMEOUT != 0) && (timeout_cnt == TIMEOUT_LAST);

  // Opcode classification of the latched instruction.
  always_comb begin
    is_load   = (instr_opcode_in == OP_LOAD);
    is_store  = (instr_opcode_in == OP_STORE);
    is_legal  = 1'b0;
    writes_rd = 1'b0;
    case (instr_opcode_in)
      OP_ARITH_R, OP_ARITH_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD: begin
        is_legal  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_BRANCH, OP_STORE, OP_SYSTEM: is_legal = 1'b1;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state <= S_IDLE;
    else           state <= state_next;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_next        = state;
    cause_next        = trap_cause_out;
    bus_cyc_out       = 1'b0;
    bus_stb_out       = 1'b0;
    bus_we_out        = 1'b0;
    bus_addr_sel_out  = 1'b0;
    instr_latch_out   = 1'b0;
    operand_latch_out = 1'b0;
    load_latch_out    = 1'b0;
    writeback_out     = 1'b0;
    pc_update_out     = 1'b0;
    pc_sel_out        = PC_SEL_SEQ;
    trap_out          = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        bus_cyc_out = 1'b1;
        bus_stb_out = 1'b1;
        if (bus_err_in) begin
          state_next = S_TRAP;
          cause_next = CAUSE_BUS_ERR;
        end else if (bus_ack_in) begin
          instr_latch_out = 1'b1;
          state_next      = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        operand_latch_out = 1'b1;
        if (!is_legal) begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else begin
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: state_next = (is_load || is_store) ? S_MEM : S_WRITEBACK;
      S_MEM: begin
        bus_cyc_out      = 1'b1;
        bus_stb_out      = 1'b1;
        bus_addr_sel_out = 1'b1;
        bus_we_out       = is_store;
        if (bus_err_in) begin
          state_next = S_TRAP;
          cause_next = CAUSE_BUS_ERR;
        end else if (bus_ack_in) begin
          load_latch_out = is_load;
          state_next     = S_WRITEBACK;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_WRITEBACK: begin
        writeback_out = writes_rd;
        pc_update_out = 1'b1;
        if (instr_opcode_in == OP_JAL || (instr_opcode_in == OP_BRANCH && branch_taken_in))
          pc_sel_out = PC_SEL_REL;
        else if (instr_opcode_in == OP_JALR)
          pc_sel_out = PC_SEL_REG;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        trap_out      = 1'b1;
        pc_update_out = 1'b1;
        pc_sel_out    = PC_SEL_TRAP;
        state_next    = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Bus wait counter: cleared on entry to a bus state, saturating while waiting.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      timeout_cnt <= '0;
    end else if (state_next != state && (state_next == S_FETCH || state_next == S_MEM)) begin
      timeout_cnt <= '0;
    end else if ((state == S_FETCH || state == S_MEM) && state_next == state) begin
      if (timeout_cnt != TIMEOUT_MAX) timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
    end
  end

  // Trap cause captured on trap entry, held otherwise.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) trap_cause_out <= CAUSE_ILLEGAL;
    else           trap_cause_out <= cause_next;
  end

  // Retired-instruction counter, bumped once per writeback.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in)                 instret_out <= '0;
    else if (state == S_WRITEBACK) instret_out <= instret_out + INSTRET_W'(1);
  end

endmodule
